// File: rtl/ram_arb_pkg.sv
// Shared definitions for the ram_arb RAM access arbiter:
// FSM state encoding, default strobe length and small helpers.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int WAIT_CYC_DEF = 2;

    // "last served" value that makes requester 0 win the first contention
    localparam logic LAST_RESET = 1'b1;

    function automatic logic grant_idx(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester handshake and external RAM control signals of ram_arb.
// The bidirectional RAM data bus stays a plain port on the arbiter.
interface ram_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [1:0]        REQ;
    logic [1:0]        WR;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA0;
    logic [DATA_W-1:0] WDATA1;
    logic [1:0]        ACK;
    logic [DATA_W-1:0] RDATA;
    logic              BUSY;
    logic [ADDR_W-1:0] A_RAM;
    logic              CE_RAM;
    logic              WE_RAM;

    modport slave (
        input  REQ, WR, ADDR0, ADDR1, WDATA0, WDATA1,
        output ACK, RDATA, BUSY, A_RAM, CE_RAM, WE_RAM
    );

    modport master (
        output REQ, WR, ADDR0, ADDR1, WDATA0, WDATA1,
        input  ACK, RDATA, BUSY, A_RAM, CE_RAM, WE_RAM
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request wins outright, on a tie
// the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Arbitrates two requesters onto one asynchronous external RAM, running an
// IDLE/SETUP/STROBE/HOLD cycle per access with a WAIT_CYC-long strobe.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic              MAIN_CLK,
    input  logic              RST_N,
    ram_arb_if.slave          bus,
    inout  wire  [DATA_W-1:0] D_RAM
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        rr_grant;
    logic              win;
    logic              drive_en;

    rr_arb2 u_rr_arb2 (
        .req   (bus.REQ),
        .last  (last_q),
        .grant (rr_grant)
    );

    assign win = grant_idx(rr_grant);

    always_ff @(posedge MAIN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= LAST_RESET;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The winner and its request are frozen in IDLE; nothing is resampled
    // until the FSM returns there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.REQ) begin
                    state_d = ST_SETUP;
                    grant_d = rr_grant;
                    last_d  = win;
                    wr_d    = bus.WR[win];
                    addr_d  = win ? bus.ADDR1 : bus.ADDR0;
                    wdata_d = win ? bus.WDATA1 : bus.WDATA0;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                    if (!wr_q) begin
                        rdata_d = D_RAM;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign drive_en   = (state_q != ST_IDLE) && wr_q;
    assign D_RAM      = drive_en ? wdata_q : {DATA_W{1'bz}};

    assign bus.ACK    = (state_q == ST_HOLD) ? grant_q : 2'b00;
    assign bus.BUSY   = (state_q != ST_IDLE);
    assign bus.CE_RAM = (state_q == ST_IDLE);
    assign bus.WE_RAM = !((state_q == ST_STROBE) && wr_q);
    assign bus.A_RAM  = addr_q;
    assign bus.RDATA  = rdata_q;

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb: directed and random traffic against a
// request-level reference model plus a small external RAM model.
module tb_ram_arb;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W1 = 2;
    localparam int W2 = 5;
    localparam logic [DW-1:0] RAM2_DATA = 8'h3C;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    wire [DW-1:0] d_ram1;
    wire [DW-1:0] d_ram2;

    ram_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W1)) dut1 (
        .MAIN_CLK (clk),
        .RST_N    (rst_n),
        .bus      (bus1),
        .D_RAM    (d_ram1)
    );

    ram_arb #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W2)) dut2 (
        .MAIN_CLK (clk),
        .RST_N    (rst_n),
        .bus      (bus2),
        .D_RAM    (d_ram2)
    );

    // External RAM for dut1: output window opened by the bench during reads
    logic [DW-1:0] ram_mem [256];
    logic          rd_drive1 = 1'b0;

    assign d_ram1 = (rd_drive1 && !bus1.CE_RAM && bus1.WE_RAM) ? ram_mem[bus1.A_RAM[7:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (bus1.CE_RAM === 1'b0 && bus1.WE_RAM === 1'b0)
            ram_mem[bus1.A_RAM[7:0]] <= d_ram1;
    end

    assign d_ram2 = (!bus2.CE_RAM && bus2.WE_RAM) ? RAM2_DATA : {DW{1'bz}};

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            last_srv = 1;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_rdata = '0;

    // Requester-side stimulus
    logic [1:0]    req_in = '0;
    logic [1:0]    wr_in  = '0;
    logic [AW-1:0] addr_in [2];
    logic [DW-1:0] wdata_in [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Undriven bus: z in a four-state simulator, zero in a two-state one
    task automatic check_hiz(input string tag, input logic [DW-1:0] v);
        checks++;
        assert (v === {DW{1'bz}} || v === {DW{1'b0}}) else begin
            failures++;
            $error("FAIL %s observed=%h expected=zz", tag, v);
        end
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    task automatic apply_inputs();
        bus1.REQ    = req_in;
        bus1.WR     = wr_in;
        bus1.ADDR0  = addr_in[0];
        bus1.ADDR1  = addr_in[1];
        bus1.WDATA0 = wdata_in[0];
        bus1.WDATA1 = wdata_in[1];
    endtask

    task automatic new_request(input int k, input logic wr, input logic [AW-1:0] a);
        req_in[k]   = 1'b1;
        wr_in[k]    = wr;
        addr_in[k]  = a;
        wdata_in[k] = DW'($urandom_range(1, 255));
    endtask

    // One complete RAM cycle of dut1, starting from an IDLE negedge with the
    // requests already applied and ending on the following IDLE negedge.
    task automatic serve_one(input bit hold_req, input bit drop_after_grant,
                             input bit glitch_other, output logic [1:0] ack_seen);
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          is_wr;
        logic [1:0]    exp_ack;
        w        = pick(req_in, last_srv);
        last_srv = w;
        a        = addr_in[w];
        wd       = wdata_in[w];
        is_wr    = wr_in[w];
        exp_ack  = (w == 0) ? 2'b01 : 2'b10;
        ack_seen = 2'b00;
        for (int n = 1; n <= W1 + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("setup_ce", bus1.CE_RAM, 0);
                check("setup_we", bus1.WE_RAM, 1);
                check("setup_addr", bus1.A_RAM, a);
                check("setup_busy", bus1.BUSY, 1);
                check("setup_ack", bus1.ACK, 0);
                if (is_wr) check("setup_dram", d_ram1, wd);
                else       check_hiz("setup_dram_hiz", d_ram1);
                if (!is_wr) rd_drive1 = 1'b1;
                if (drop_after_grant) begin
                    req_in[w] = 1'b0;
                    apply_inputs();
                end
            end else if (n <= W1 + 1) begin
                check("strobe_ce", bus1.CE_RAM, 0);
                check("strobe_we", bus1.WE_RAM, is_wr ? 0 : 1);
                check("strobe_addr", bus1.A_RAM, a);
                check("strobe_ack", bus1.ACK, 0);
                if (is_wr) check("strobe_dram", d_ram1, wd);
                if (glitch_other && n == 2) begin
                    req_in[1-w] = 1'b1;
                    apply_inputs();
                end
            end else begin
                rd_drive1 = 1'b0;
                #1;
                ack_seen = bus1.ACK;
                check("hold_ack", bus1.ACK, exp_ack);
                check("hold_ce", bus1.CE_RAM, 0);
                check("hold_we", bus1.WE_RAM, 1);
                check("hold_addr", bus1.A_RAM, a);
                if (is_wr) begin
                    check("hold_dram", d_ram1, wd);
                    ref_mem[a[7:0]] = wd;
                end else begin
                    check_hiz("hold_dram_hiz", d_ram1);
                    exp_rdata = ref_mem[a[7:0]];
                end
                check("hold_rdata", bus1.RDATA, exp_rdata);
                if (glitch_other) req_in[1-w] = 1'b0;
                if (!hold_req) req_in[w] = 1'b0;
                apply_inputs();
            end
        end
        @(negedge clk);
        check("idle_busy", bus1.BUSY, 0);
        check("idle_ce", bus1.CE_RAM, 1);
        check("idle_we", bus1.WE_RAM, 1);
        check("idle_ack", bus1.ACK, 0);
        check("idle_rdata", bus1.RDATA, exp_rdata);
        check_hiz("idle_dram_hiz", d_ram1);
    endtask

    initial begin
        logic [1:0] ack_seen;
        logic [1:0] add;
        int         lat;
        int         busy_cnt;
        bit         got;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        addr_in[0] = '0;  addr_in[1] = '0;
        wdata_in[0] = '0; wdata_in[1] = '0;
        rst_n = 1'b0;
        apply_inputs();
        bus2.REQ = '0; bus2.WR = '0; bus2.ADDR0 = '0; bus2.ADDR1 = '0;
        bus2.WDATA0 = '0; bus2.WDATA1 = '0;

        $display("[TB] reset values");
        @(negedge clk);
        check("rst_ce", bus1.CE_RAM, 1);
        check("rst_we", bus1.WE_RAM, 1);
        check("rst_addr", bus1.A_RAM, 0);
        check("rst_ack", bus1.ACK, 0);
        check("rst_rdata", bus1.RDATA, 0);
        check("rst_busy", bus1.BUSY, 0);
        check_hiz("rst_dram_hiz", d_ram1);
        @(negedge clk);

        $display("[TB] directed write then read at 0x0012");
        req_in = 2'b01; wr_in = 2'b01; addr_in[0] = 16'h0012; wdata_in[0] = 8'hA5;
        apply_inputs();
        rst_n = 1'b1;
        serve_one(1'b0, 1'b0, 1'b0, ack_seen);
        check("wr_ack_value", ack_seen, 2'b01);

        req_in = 2'b10; wr_in = 2'b00; addr_in[1] = 16'h0012; wdata_in[1] = 8'h5A;
        apply_inputs();
        serve_one(1'b0, 1'b0, 1'b0, ack_seen);
        check("rd_ack_value", ack_seen, 2'b10);
        check("rd_data_a5", bus1.RDATA, 8'hA5);

        $display("[TB] preload address pool");
        for (int a = 0; a < 8; a++) begin
            req_in = '0;
            new_request(a % 2, 1'b1, AW'(a));
            apply_inputs();
            serve_one(1'b0, 1'b0, 1'b0, ack_seen);
        end

        $display("[TB] contention with both requests held");
        req_in = '0;
        new_request(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        new_request(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        apply_inputs();
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b1, 1'b0, 1'b0, ack_seen);
            check("contention_order", ack_seen, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        req_in = '0;
        apply_inputs();

        $display("[TB] early drop after grant, short request while busy");
        new_request(0, 1'b0, 16'h0003);
        apply_inputs();
        serve_one(1'b0, 1'b1, 1'b1, ack_seen);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("glitch_ignored_busy", bus1.BUSY, 0);
            check("glitch_ignored_ack", bus1.ACK, 0);
        end

        $display("[TB] random traffic");
        for (int it = 0; it < 24; it++) begin
            add = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                if (!req_in[k] && add[k])
                    new_request(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
            end
            if (req_in == 2'b00)
                new_request(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
            apply_inputs();
            serve_one(1'b0, 1'b0, 1'b0, ack_seen);
        end
        for (int i = 0; i < 2 && req_in != 2'b00; i++)
            serve_one(1'b0, 1'b0, 1'b0, ack_seen);

        $display("[TB] reset in the middle of a write strobe");
        new_request(0, 1'b1, 16'h00FF);
        wdata_in[0] = 8'h77;
        apply_inputs();
        @(negedge clk);
        @(negedge clk);
        check("abort_in_strobe", bus1.WE_RAM, 0);
        rst_n = 1'b0;
        #1;
        check("abort_ce", bus1.CE_RAM, 1);
        check("abort_we", bus1.WE_RAM, 1);
        check_hiz("abort_dram_hiz", d_ram1);
        check("abort_ack", bus1.ACK, 0);
        check("abort_busy", bus1.BUSY, 0);
        check("abort_rdata", bus1.RDATA, 0);
        check("abort_addr", bus1.A_RAM, 0);
        last_srv  = 1;
        exp_rdata = '0;
        req_in    = '0;
        apply_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_no_ack", bus1.ACK, 0);
        end
        new_request(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        new_request(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        apply_inputs();
        rst_n = 1'b1;
        serve_one(1'b0, 1'b0, 1'b0, ack_seen);
        check("post_reset_winner", ack_seen, 2'b01);
        serve_one(1'b0, 1'b0, 1'b0, ack_seen);

        $display("[TB] long strobe instance, single read");
        bus2.REQ = 2'b10; bus2.WR = 2'b00; bus2.ADDR1 = 16'h0040;
        lat = 0; busy_cnt = 0; got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (bus2.BUSY) busy_cnt++;
            if (bus2.ACK != 2'b00) begin
                got = 1;
                lat = c;
                check("w5_ack_value", bus2.ACK, 2'b10);
                check("w5_rdata", bus2.RDATA, RAM2_DATA);
                bus2.REQ = 2'b00;
            end
        end
        check("w5_ack_seen", got, 1);
        check("w5_latency", lat, W2 + 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus2.BUSY) busy_cnt++;
        end
        check("w5_busy_cycles", busy_cnt, W2 + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
